iram_loader: RTL and testbench
==============================

Name: iram_loader

Overview:
- Boot-time writer for the instruction RAM.
- Accepts a byte stream from a host link (UART/debug bridge) over a valid/ready handshake and packs the bytes little-endian into N-bit words.
- Drives a registered word-write port (address, data, enable) into the instruction memory.
- Loads a host-specified number of words starting at address 0, then signals completion so the core may be released from reset.

Parameters:
- N, 32, instruction word width in bits; must be a multiple of 8.
- K, 512, number of instruction memory locations; also the maximum load length.
- BYTES, N/8, bytes per word; derived, not overridden.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Rst  input  1  asynchronous, active-low reset (0 = reset).
- Start  input  1  one-cycle request to begin a load; honoured only in IDLE.
- Len  input  $clog2(K)+1  number of words to load; sampled when Start is honoured.
- Abort  input  1  synchronous cancel of a load in progress.
- In_Data  input  8  stream byte.
- In_Valid  input  1  In_Data valid.
- In_Ready  output  1  loader accepts a byte this cycle.
- WrEn  output  1  word write strobe to instruction memory.
- WrAddr  output  $clog2(K)  word address of write.
- WrData  output  N  word to write.
- Busy  output  1  load in progress.
- Done  output  1  one-cycle pulse: load finished successfully.
- Err  output  1  one-cycle pulse: Len > K rejected.
- Count  output  $clog2(K)+1  words written in current/last load.

Behaviour:
- Reset (Rst=0, async): state IDLE; In_Ready, WrEn, Busy, Done, Err = 0; WrAddr, WrData, Count = 0; byte lane and partial word cleared. Reset mid-load discards the partial word; no write is issued.
- States: IDLE, LOAD.
- Byte transfer: occurs only on a cycle with In_Valid=1 and In_Ready=1. In_Ready = (state==LOAD), decoded from state; it does not depend on In_Valid.
- IDLE → LOAD: Start=1 and 1 <= Len <= K.
  - Latch Len.
  - Clear word index, byte lane and Count.
  - Busy=1 from the next cycle.
- Start in IDLE with Len=0: Done=1 for exactly the next cycle; stay IDLE; Count=0.
- Start in IDLE with Len>K: Err=1 for exactly the next cycle; stay IDLE; no writes.
- Start while in LOAD: ignored.
- Byte packing: byte at lane b goes to word bits [8b+7:8b]. The first byte of each word is lane 0. The lane counter wraps BYTES-1 → 0.
- Word completion: on acceptance of the lane-(BYTES-1) byte, in the next cycle:
  - WrEn=1 for exactly one cycle.
  - WrAddr = current word index; WrData = the assembled word.
  - Count increments.
  - The word index then increments.
- Latency: last byte of a word accepted in cycle T → write visible in cycle T+1.
- Back-to-back transfers: sustained at one byte per cycle with no stalls; WrEn can therefore be high at most once every BYTES cycles.
- Final word: on acceptance of the last byte of word Len-1:
  - State → IDLE, so In_Ready=0 and Busy=0 from T+1.
  - In T+1, WrEn=1 and Done=1 together (same cycle).
- WrAddr and WrData hold their last values when WrEn=0.
- Abort=1 in LOAD:
  - Next cycle: IDLE, Busy=0.
  - Partial word discarded; no write; Done and Err stay 0.
  - Count keeps the number of words already written.
  - If Abort coincides with acceptance of a word-completing byte, Abort wins: the byte is dropped and no write occurs.
- Abort in IDLE: no effect. Abort and Start in the same IDLE cycle: Start is honoured.
- In_Valid=0 gaps: state and lane hold indefinitely; there is no timeout.
- Word index never exceeds Len-1, so WrAddr never wraps.

Test Plan:
- Reset then Start, Len=2, bytes 0x13,0x00,0x00,0x00,0x93,0x80,0x10,0x00 streamed continuously:
  - -> WrEn at addr 0 with 0x00000013, then 4 cycles later addr 1 with 0x00108093.
  - -> Done coincident with the second WrEn; Count=2; Busy=0 afterwards.
- Len=1 with In_Valid toggling 1,0,0,1,1,0,1 carrying 0xEF,0xBE,0xAD,0xDE:
  - -> single write at addr 0 with 0xDEADBEEF, one cycle after the last accepted byte.
- Start Len=0 -> Done pulse next cycle, no WrEn. Start Len=513 (K=512) -> Err pulse next cycle, Busy stays 0.
- Len=3; assert Abort after 6 bytes -> exactly one write (addr 0); Busy=0 next cycle; Done=0; Count=1.
  - Then a new Start with Len=1 -> write at addr 0.
- Drive Rst=0 mid-word during Len=2 (after 5 bytes) -> all outputs 0 immediately; no further WrEn.
  - After release, a fresh load behaves as in scenario 1.
- Start pulsed again during LOAD with Len=1 -> ignored; the original Len=2 load completes with Count=2.

Source files
------------

// File: rtl/iram_loader_if.sv
// Host byte stream, control and instruction-RAM write port of the boot loader.
// The host/bench side uses master; the loader uses slave.
interface iram_loader_if #(
  parameter int N = 32,
  parameter int K = 512
);
  localparam int LW = $clog2(K) + 1;
  localparam int AW = $clog2(K);

  logic          start;
  logic [LW-1:0] len;
  logic          abort;
  logic [7:0]    in_dat;
  logic          in_vld;
  logic          in_rdy;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [N-1:0]  wr_dat;
  logic          busy;
  logic          done;
  logic          err;
  logic [LW-1:0] count;

  modport master (
    output start, len, abort, in_dat, in_vld,
    input  in_rdy, wr_en, wr_addr, wr_dat, busy, done, err, count
  );

  modport slave (
    input  start, len, abort, in_dat, in_vld,
    output in_rdy, wr_en, wr_addr, wr_dat, busy, done, err, count
  );
endinterface

// File: rtl/iram_loader.sv
// Boot loader: packs a little-endian byte stream into N-bit words and writes words 0..len-1.
// Latency 1 cycle last byte -> write; in_rdy is high for the whole LOAD state, no internal buffering.
module iram_loader #(
  parameter int N = 32,
  parameter int K = 512
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  iram_loader_if.slave  bus
);
  localparam int BYTES = N / 8;
  localparam int LW    = $clog2(K) + 1;
  localparam int AW    = $clog2(K);
  localparam int LNW   = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic {IDLE, LOAD} state_e;

  state_e         state_q, state_d;
  logic [LW-1:0]  len_q, len_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic [LNW-1:0] lane_q, lane_d;
  logic [N-1:0]   word_q, word_d;
  logic           wr_en_q, wr_en_d;
  logic [AW-1:0]  wr_addr_q, wr_addr_d;
  logic [N-1:0]   wr_dat_q, wr_dat_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic [LW-1:0]  count_q, count_d;

  logic           accept;
  logic           last_lane;
  logic           last_word;
  logic [N-1:0]   word_asm;

  // Abort beats a coincident byte, so a completing byte is dropped rather than written.
  assign accept    = (state_q == LOAD) && bus.in_vld && !bus.abort;
  assign last_lane = (lane_q == LNW'(BYTES - 1));
  assign last_word = ({1'b0, idx_q} == (len_q - LW'(1)));

  always_comb begin
    word_asm = word_q;
    word_asm[{lane_q, 3'b000} +: 8] = bus.in_dat;
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    lane_d    = lane_q;
    word_d    = word_q;
    count_d   = count_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_dat_d  = wr_dat_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.len == '0) begin
            done_d  = 1'b1;
            count_d = '0;
          end else if (bus.len > LW'(K)) begin
            err_d = 1'b1;
          end else begin
            state_d = LOAD;
            len_d   = bus.len;
            idx_d   = '0;
            lane_d  = '0;
            word_d  = '0;
            count_d = '0;
          end
        end
      end
      LOAD: begin
        if (bus.abort) begin
          state_d = IDLE;
          lane_d  = '0;
          word_d  = '0;
        end else if (accept) begin
          word_d = word_asm;
          if (last_lane) begin
            lane_d    = '0;
            wr_en_d   = 1'b1;
            wr_addr_d = idx_q;
            wr_dat_d  = word_asm;
            count_d   = count_q + LW'(1);
            if (last_word) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + AW'(1);
            end
          end else begin
            lane_d = lane_q + LNW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      lane_q    <= '0;
      word_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_dat_q  <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      lane_q    <= lane_d;
      word_q    <= word_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_dat_q  <= wr_dat_d;
      done_q    <= done_d;
      err_q     <= err_d;
      count_q   <= count_d;
    end
  end

  assign bus.in_rdy  = (state_q == LOAD);
  assign bus.busy    = (state_q == LOAD);
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_dat  = wr_dat_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.count   = count_q;
endmodule

// File: tb/tb_iram_loader.sv
// Bench for iram_loader: expected writes are queued as bytes are driven and matched by a write monitor.
module tb_iram_loader;
  localparam int N = 32;
  localparam int K = 512;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  iram_loader_if #(.N(N), .K(K)) bus ();
  iram_loader #(.N(N), .K(K)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  typedef struct packed {
    logic [8:0]  addr;
    logic [31:0] data;
    logic        done;
  } exp_t;

  exp_t sb_q[$];
  int   wr_cyc_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) done_cnt++;
      if (bus.wr_en === 1'b1) begin
        wr_cyc_q.push_back(cyc);
        n_vec++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_write got addr=%0d data=%h, none expected", bus.wr_addr, bus.wr_dat);
        end else begin
          e = sb_q.pop_front();
          if ({bus.wr_addr, bus.wr_dat, bus.done} !== e)
            begin
              n_err++;
              $display("FAIL write got addr=%0d data=%h done=%b, expected addr=%0d data=%h done=%b",
                       bus.wr_addr, bus.wr_dat, bus.done, e.addr, e.data, e.done);
            end
        end
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    bus.in_dat = b;
    bus.in_vld = 1'b1;
    @(negedge clk);
    while (bus.in_rdy !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout in_rdy=%b, required 1 within 20 cycles", bus.in_rdy);
    end
    @(posedge clk); #1;
    acc_cyc = cyc - 1;
  endtask

  task automatic start_load(input logic [9:0] l);
    bus.start = 1'b1;
    bus.len   = l;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({bus.in_rdy, bus.wr_en, bus.busy, bus.done, bus.err} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_flags got %b, required 00000", {bus.in_rdy, bus.wr_en, bus.busy, bus.done, bus.err});
    end
    n_vec++;
    if (bus.wr_addr !== 9'd0 || bus.wr_dat !== 32'd0 || bus.count !== 10'd0) begin
      n_err++;
      $display("FAIL reset_values got addr=%0d data=%h count=%0d, required 0", bus.wr_addr, bus.wr_dat, bus.count);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [7:0] s [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h80, 8'h10, 8'h00};
    int d0 = done_cnt;
    wr_cyc_q.delete();
    start_load(10'd2);
    sb_q.push_back('{9'd0, 32'h0000_0013, 1'b0});
    sb_q.push_back('{9'd1, 32'h0010_8093, 1'b1});
    for (int i = 0; i < 8; i++) send_byte(s[i]);
    bus.in_vld = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL basic_pending got %0d writes outstanding, required 0", sb_q.size());
    end
    n_vec++;
    if (wr_cyc_q.size() != 2) begin
      n_err++;
      $display("FAIL basic_nwrites got %0d, required 2", wr_cyc_q.size());
    end else begin
      n_vec++;
      if (wr_cyc_q[1] - wr_cyc_q[0] != 4) begin
        n_err++;
        $display("FAIL basic_spacing got %0d cycles, required 4", wr_cyc_q[1] - wr_cyc_q[0]);
      end
      n_vec++;
      if (wr_cyc_q[1] != acc_cyc + 1) begin
        n_err++;
        $display("FAIL basic_latency got cycle %0d, required %0d", wr_cyc_q[1], acc_cyc + 1);
      end
    end
    n_vec++;
    if (bus.count !== 10'd2 || bus.busy !== 1'b0 || done_cnt - d0 != 1) begin
      n_err++;
      $display("FAIL basic_end got count=%0d busy=%b done_pulses=%0d, required 2 0 1",
               bus.count, bus.busy, done_cnt - d0);
    end
  endtask

  task automatic test_gappy();
    logic [6:0] pat = 7'b1011001;
    logic [7:0] s [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    int k = 0;
    wr_cyc_q.delete();
    start_load(10'd1);
    sb_q.push_back('{9'd0, 32'hDEAD_BEEF, 1'b1});
    for (int i = 0; i < 7; i++) begin
      bus.in_vld = pat[i];
      bus.in_dat = s[k];
      @(posedge clk); #1;
      if (pat[i]) begin
        acc_cyc = cyc - 1;
        k++;
      end
      if (i == 5) begin
        n_vec++;
        if (bus.busy !== 1'b1 || bus.wr_en !== 1'b0) begin
          n_err++;
          $display("FAIL gappy_mid got busy=%b wr_en=%b, required 1 0", bus.busy, bus.wr_en);
        end
      end
    end
    bus.in_vld = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (wr_cyc_q.size() != 1 || sb_q.size() != 0) begin
      n_err++;
      $display("FAIL gappy_nwrites got %0d writes %0d pending, required 1 0", wr_cyc_q.size(), sb_q.size());
    end else begin
      n_vec++;
      if (wr_cyc_q[0] != acc_cyc + 1) begin
        n_err++;
        $display("FAIL gappy_latency got cycle %0d, required %0d", wr_cyc_q[0], acc_cyc + 1);
      end
    end
    n_vec++;
    if (bus.count !== 10'd1 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL gappy_end got count=%0d busy=%b, required 1 0", bus.count, bus.busy);
    end
  endtask

  task automatic test_len_edges();
    wr_cyc_q.delete();
    start_load(10'd0);
    n_vec++;
    if (bus.done !== 1'b1 || bus.wr_en !== 1'b0 || bus.busy !== 1'b0 || bus.count !== 10'd0) begin
      n_err++;
      $display("FAIL len0 got done=%b wr_en=%b busy=%b count=%0d, required 1 0 0 0",
               bus.done, bus.wr_en, bus.busy, bus.count);
    end
    @(posedge clk); #1;
    n_vec++;
    if (bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL len0_pulse got done=%b, required 0", bus.done);
    end
    start_load(10'd513);
    n_vec++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL len513 got err=%b busy=%b, required 1 0", bus.err, bus.busy);
    end
    @(posedge clk); #1;
    n_vec++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b0 || wr_cyc_q.size() != 0) begin
      n_err++;
      $display("FAIL len513_after got err=%b busy=%b writes=%0d, required 0 0 0",
               bus.err, bus.busy, wr_cyc_q.size());
    end
    start_load(10'd512);
    n_vec++;
    if (bus.busy !== 1'b1 || bus.err !== 1'b0) begin
      n_err++;
      $display("FAIL len512 got busy=%b err=%b, required 1 0", bus.busy, bus.err);
    end
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
  endtask

  task automatic test_abort();
    int d0 = done_cnt;
    wr_cyc_q.delete();
    start_load(10'd3);
    sb_q.push_back('{9'd0, 32'h0403_0201, 1'b0});
    for (int i = 1; i <= 6; i++) send_byte(8'(i));
    bus.abort  = 1'b1;
    bus.in_dat = 8'h07;
    @(posedge clk); #1;
    bus.abort  = 1'b0;
    bus.in_vld = 1'b0;
    n_vec++;
    if (bus.busy !== 1'b0 || bus.in_rdy !== 1'b0) begin
      n_err++;
      $display("FAIL abort_state got busy=%b in_rdy=%b, required 0 0", bus.busy, bus.in_rdy);
    end
    @(posedge clk); #1;
    n_vec++;
    if (bus.count !== 10'd1 || done_cnt != d0 || wr_cyc_q.size() != 1 || sb_q.size() != 0) begin
      n_err++;
      $display("FAIL abort_result got count=%0d done_pulses=%0d writes=%0d, required 1 0 1",
               bus.count, done_cnt - d0, wr_cyc_q.size());
    end
    start_load(10'd1);
    sb_q.push_back('{9'd0, 32'h1122_3344, 1'b1});
    send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
    bus.in_vld = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (sb_q.size() != 0 || bus.count !== 10'd1) begin
      n_err++;
      $display("FAIL abort_reload got pending=%0d count=%0d, required 0 1", sb_q.size(), bus.count);
    end
    wr_cyc_q.delete();
    start_load(10'd2);
    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
    bus.abort  = 1'b1;
    bus.in_dat = 8'hA4;
    @(posedge clk); #1;
    bus.abort  = 1'b0;
    bus.in_vld = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (wr_cyc_q.size() != 0 || bus.count !== 10'd0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL abort_on_last_lane got writes=%0d count=%0d busy=%b, required 0 0 0",
               wr_cyc_q.size(), bus.count, bus.busy);
    end
    bus.abort = 1'b1;
    start_load(10'd1);
    bus.abort = 1'b0;
    n_vec++;
    if (bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL abort_start_idle got busy=%b, required 1", bus.busy);
    end
    sb_q.push_back('{9'd0, 32'hCAFE_F00D, 1'b1});
    send_byte(8'h0D); send_byte(8'hF0); send_byte(8'hFE); send_byte(8'hCA);
    bus.in_vld = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midload();
    int wc;
    wr_cyc_q.delete();
    start_load(10'd2);
    sb_q.push_back('{9'd0, 32'h4433_2211, 1'b0});
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44); send_byte(8'h55);
    bus.in_vld = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.in_rdy, bus.wr_en, bus.busy, bus.done, bus.err} !== 5'b0 ||
        bus.wr_addr !== 9'd0 || bus.wr_dat !== 32'd0 || bus.count !== 10'd0) begin
      n_err++;
      $display("FAIL midreset_outputs got flags=%b addr=%0d data=%h count=%0d, required all 0",
               {bus.in_rdy, bus.wr_en, bus.busy, bus.done, bus.err}, bus.wr_addr, bus.wr_dat, bus.count);
    end
    wc = wr_cyc_q.size();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    n_vec++;
    if (wr_cyc_q.size() != wc || wc != 1 || sb_q.size() != 0) begin
      n_err++;
      $display("FAIL midreset_writes got %0d then %0d, pending %0d, required 1 1 0", wc, wr_cyc_q.size(), sb_q.size());
    end
  endtask

  task automatic test_start_in_load();
    int d0 = done_cnt;
    start_load(10'd2);
    sb_q.push_back('{9'd0, 32'h1312_1110, 1'b0});
    sb_q.push_back('{9'd1, 32'h1716_1514, 1'b1});
    send_byte(8'h10); send_byte(8'h11);
    bus.start = 1'b1;
    bus.len   = 10'd1;
    send_byte(8'h12);
    bus.start = 1'b0;
    for (int i = 3; i < 8; i++) send_byte(8'(8'h10 + i));
    bus.in_vld = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    n_vec++;
    if (sb_q.size() != 0 || bus.count !== 10'd2 || done_cnt - d0 != 1 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL start_in_load got pending=%0d count=%0d done_pulses=%0d busy=%b, required 0 2 1 0",
               sb_q.size(), bus.count, done_cnt - d0, bus.busy);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.len    = '0;
    bus.abort  = 1'b0;
    bus.in_dat = '0;
    bus.in_vld = 1'b0;
    fork
      monitor();
      begin
        #200000;
        $display("FAIL watchdog simulation did not complete within 200000 ns");
        $fatal(1, "watchdog expired");
      end
    join_none
    test_reset();
    test_basic();
    test_gappy();
    test_len_edges();
    test_abort();
    test_reset_midload();
    test_basic();
    test_start_in_load();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
